mult_div_unit: RTL and testbench

//   Iterative HI/LO multiply/divide unit for the MIPS core, downstream of the register file.

---
 rtl/mult_div_unit.sv | 194 +++++++++++++++++++
 tb/tb_mult_div_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative HI/LO multiply/divide unit, one result bit per clock.
// Multiply is shift-add over a 2*WIDTH product register. Divide is restoring,
// with the {remainder, quotient} pair sharing the same register.
// Optional feature macro: MDU_SIGNED_EN. When it is defined, op 00/10 are signed:
// the core runs on magnitudes and the results are sign-fixed at completion.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] rs_data_i,
   input  logic [WIDTH-1:0] rt_data_i,
   input  logic             hi_we_i,
   input  logic             lo_we_i,
   input  logic [WIDTH-1:0] wr_data_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        count_q, count_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     opb_q, opb_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
   logic                 is_div_q, is_div_d;
   logic                 div_zero_q, div_zero_d;
   logic                 done_q, done_d;

   logic [WIDTH-1:0]     rs_mag, rt_mag;
   logic [2*WIDTH-1:0]   step_acc;
   logic [WIDTH:0]       mul_sum;
   logic [WIDTH:0]       div_shift;
   logic [WIDTH-1:0]     div_diff;
   logic                 div_ge;
   logic [2*WIDTH-1:0]   prod_res;
   logic [WIDTH-1:0]     quo_res, rem_res;

`ifdef MDU_SIGNED_EN
   logic                 signed_op, rs_neg, rt_neg;
   logic                 neg_lo_q, neg_lo_d;
   logic                 neg_hi_q, neg_hi_d;

   // Convert operands to magnitudes for signed ops so the core always runs unsigned
   always_comb begin
      signed_op = ~op_i[0];
      rs_neg    = signed_op & rs_data_i[WIDTH-1];
      rt_neg    = signed_op & rt_data_i[WIDTH-1];
      rs_mag    = rs_neg ? -rs_data_i : rs_data_i;
      rt_mag    = rt_neg ? -rt_data_i : rt_data_i;
   end
`else
   logic                 unused_op_bit;
   assign unused_op_bit = op_i[0];

   // Without the signed feature every op is unsigned, operands pass straight through
   always_comb begin
      rs_mag = rs_data_i;
      rt_mag = rt_data_i;
   end
`endif

   // One iteration of either the shift-add multiply or the restoring divide
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
      div_shift = acc_q[2*WIDTH-1:WIDTH-1];
      div_ge    = (div_shift >= {1'b0, opb_q});
      div_diff  = div_shift[WIDTH-1:0] - opb_q;
      if (is_div_q) begin
         step_acc = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
      end else begin
         step_acc = {mul_sum, acc_q[WIDTH-1:1]};
      end
   end

   // Final sign fix-up applied to the last iteration's result at completion.
   // A zero divisor leaves the dividend in the remainder, so HI needs no override.
   always_comb begin
      prod_res = step_acc;
      quo_res  = step_acc[WIDTH-1:0];
      rem_res  = step_acc[2*WIDTH-1:WIDTH];
`ifdef MDU_SIGNED_EN
      if (neg_lo_q) begin
         prod_res = -step_acc;
         quo_res  = -step_acc[WIDTH-1:0];
      end
      if (neg_hi_q) begin
         rem_res = -step_acc[2*WIDTH-1:WIDTH];
      end
`endif
   end

   // Next-state logic: launch, iterate, complete, and idle MTHI/MTLO writes
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      acc_d      = acc_q;
      opb_d      = opb_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      is_div_d   = is_div_q;
      div_zero_d = div_zero_q;
      done_d     = 1'b0;
`ifdef MDU_SIGNED_EN
      neg_lo_d   = neg_lo_q;
      neg_hi_d   = neg_hi_q;
`endif
      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d    = RUN;
               count_d    = '0;
               is_div_d   = op_i[1];
               div_zero_d = op_i[1] & (rt_data_i == '0);
               acc_d      = {{WIDTH{1'b0}}, (op_i[1] ? rs_mag : rt_mag)};
               opb_d      = op_i[1] ? rt_mag : rs_mag;
`ifdef MDU_SIGNED_EN
               neg_lo_d   = rs_neg ^ rt_neg;
               neg_hi_d   = op_i[1] ? rs_neg : (rs_neg ^ rt_neg);
`endif
            end else begin
               if (hi_we_i) hi_d = wr_data_i;
               if (lo_we_i) lo_d = wr_data_i;
            end
         end
         RUN: begin
            acc_d   = step_acc;
            count_d = count_q + 1'b1;
            if (count_q == CW'(WIDTH - 1)) begin
               state_d = IDLE;
               done_d  = 1'b1;
               if (is_div_q) begin
                  hi_d = rem_res;
                  lo_d = div_zero_q ? '1 : quo_res;
               end else begin
                  hi_d = prod_res[2*WIDTH-1:WIDTH];
                  lo_d = prod_res[WIDTH-1:0];
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers with synchronous reset that aborts any operation in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         count_q    <= '0;
         acc_q      <= '0;
         opb_q      <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         is_div_q   <= 1'b0;
         div_zero_q <= 1'b0;
         done_q     <= 1'b0;
`ifdef MDU_SIGNED_EN
         neg_lo_q   <= 1'b0;
         neg_hi_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         acc_q      <= acc_d;
         opb_q      <= opb_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         is_div_q   <= is_div_d;
         div_zero_q <= div_zero_d;
         done_q     <= done_d;
`ifdef MDU_SIGNED_EN
         neg_lo_q   <= neg_lo_d;
         neg_hi_q   <= neg_hi_d;
`endif
      end
   end

   assign busy_o = (state_q == RUN);
   assign done_o = done_q;
   assign hi_o   = hi_q;
   assign lo_o   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized bench for mult_div_unit with a behavioural
// HI/LO model (plain 64-bit arithmetic plus a countdown) checked every cycle,
// and literal expectations for the hand-worked cases.
module tb_mult_div_unit;

   localparam int  WIDTH = 32;
   localparam time HALF  = 5;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i;
   logic [1:0]  op_i;
   logic [31:0] rs_data_i, rt_data_i, wr_data_i;
   logic        hi_we_i, lo_we_i;
   logic        busy_o, done_o;
   logic [31:0] hi_o, lo_o;

   int checks_total  = 0;
   int checks_passed = 0;
   bit cmp_en        = 1'b0;

   logic        m_busy = 1'b0;
   logic        m_done = 1'b0;
   logic [31:0] m_hi   = '0;
   logic [31:0] m_lo   = '0;
   logic [63:0] m_pend = '0;
   int          m_left = 0;

   mult_div_unit #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .start_i   (start_i),
      .op_i      (op_i),
      .rs_data_i (rs_data_i),
      .rt_data_i (rt_data_i),
      .hi_we_i   (hi_we_i),
      .lo_we_i   (lo_we_i),
      .wr_data_i (wr_data_i),
      .busy_o    (busy_o),
      .done_o    (done_o),
      .hi_o      (hi_o),
      .lo_o      (lo_o)
   );

   // Free-running clock
   always #HALF clk = ~clk;

   // Architectural result of an operation as {HI, LO}, from plain arithmetic
   function automatic logic [63:0] modelResult(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      bit     signed_op;
      longint sa, sb, q, r;
      logic [63:0] p;
`ifdef MDU_SIGNED_EN
      signed_op = !op[0];
`else
      signed_op = 1'b0;
`endif
      sa = $signed(a);
      sb = $signed(b);
      if (!op[1]) begin
         if (signed_op) p = sa * sb;
         else           p = {32'b0, a} * {32'b0, b};
         return p;
      end
      if (b == 32'd0) return {a, 32'hFFFFFFFF};
      if (signed_op) begin
         if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
         q = sa / sb;
         r = sa % sb;
         p = {r[31:0], q[31:0]};
         return p;
      end
      return {a % b, a / b};
   endfunction

   // Cycle-level behavioural model: a pending result revealed WIDTH edges after launch
   always @(posedge clk) begin
      if (rst) begin
         m_busy = 1'b0;
         m_done = 1'b0;
         m_hi   = '0;
         m_lo   = '0;
         m_left = 0;
      end else begin
         m_done = 1'b0;
         if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
               m_busy = 1'b0;
               m_done = 1'b1;
               m_hi   = m_pend[63:32];
               m_lo   = m_pend[31:0];
            end
         end else if (start_i) begin
            m_pend = modelResult(op_i, rs_data_i, rt_data_i);
            m_busy = 1'b1;
            m_left = WIDTH;
         end else begin
            if (hi_we_i) m_hi = wr_data_i;
            if (lo_we_i) m_lo = wr_data_i;
         end
      end
   end

   // Single comparison with a FAIL line on mismatch
   task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks_total++;
      if (act === exp) checks_passed++;
      else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Compare every DUT output against the model
   task automatic checkOutput();
      check1("busy", {31'b0, busy_o}, {31'b0, m_busy});
      check1("done", {31'b0, done_o}, {31'b0, m_done});
      check1("hi",   hi_o, m_hi);
      check1("lo",   lo_o, m_lo);
   endtask

   // Per-cycle compare process, away from the active edge
   always @(negedge clk) begin
      if (cmp_en) checkOutput();
   end

   // Drive one cycle of inputs, changed just after the falling edge
   task automatic applyStimulus(input logic r, input logic s, input logic [1:0] op,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic hw, input logic lw, input logic [31:0] wd);
      @(negedge clk);
      #1;
      rst       = r;
      start_i   = s;
      op_i      = op;
      rs_data_i = a;
      rt_data_i = b;
      hi_we_i   = hw;
      lo_we_i   = lw;
      wr_data_i = wd;
   endtask

   task automatic applyIdle();
      applyStimulus(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
   endtask

   // Pin DUT and model against hand-computed values just after an edge
   task automatic checkLiteral(input string name, input logic [31:0] eh, input logic [31:0] el);
      check1({name, "_hi"},       hi_o, eh);
      check1({name, "_lo"},       lo_o, el);
      check1({name, "_model_hi"}, m_hi, eh);
      check1({name, "_model_lo"}, m_lo, el);
   endtask

   // Launch an operation, run it to completion and check the done pulse
   task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      applyStimulus(1'b0, 1'b1, op, a, b, 1'b0, 1'b0, 32'h0);
      repeat (WIDTH) applyIdle();
      @(posedge clk);
      #2;
      check1("done_pulse", {31'b0, done_o}, 32'd1);
   endtask

   function automatic logic [31:0] pickOperand();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFFFFFF;
         3: return 32'h80000000;
         4: return 32'h7FFFFFFF;
         5: return $urandom_range(1, 20);
         default: return $urandom;
      endcase
   endfunction

   // Watchdog so the run always ends with a summary
   initial begin
      #(HALF * 2 * 90000);
      checks_total++;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

   // Directed cases followed by randomized traffic
   initial begin
      rst = 1'b1; start_i = 1'b0; op_i = 2'b00; rs_data_i = '0; rt_data_i = '0;
      hi_we_i = 1'b0; lo_we_i = 1'b0; wr_data_i = '0;
      repeat (2) @(posedge clk);
      #2;
      cmp_en = 1'b1;
      check1("reset_busy", {31'b0, busy_o}, 32'd0);
      checkLiteral("reset", 32'h0, 32'h0);
      applyIdle();

      runOp(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
      checkLiteral("multu_max", 32'hFFFFFFFE, 32'h00000001);
      runOp(2'b11, 32'd100, 32'd7);
      checkLiteral("divu_100_7", 32'h00000002, 32'h0000000E);
      runOp(2'b11, 32'h1234, 32'h0);
      checkLiteral("divu_zero", 32'h00001234, 32'hFFFFFFFF);
      runOp(2'b00, 32'hFFFFFFFD, 32'd5);
`ifdef MDU_SIGNED_EN
      checkLiteral("mult_neg3_5", 32'hFFFFFFFF, 32'hFFFFFFF1);
      runOp(2'b10, 32'hFFFFFFF9, 32'd2);
      checkLiteral("div_neg7_2", 32'hFFFFFFFF, 32'hFFFFFFFD);
      runOp(2'b10, 32'h80000000, 32'hFFFFFFFF);
      checkLiteral("div_minneg", 32'h0, 32'h80000000);
`else
      checkLiteral("mult_neg3_5", 32'h00000004, 32'hFFFFFFF1);
`endif

      applyStimulus(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 32'hAA);
      @(posedge clk);
      #2;
      check1("mthi_idle", hi_o, 32'hAA);
      applyStimulus(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h5A);
      applyStimulus(1'b0, 1'b1, 2'b01, 32'd3, 32'd4, 1'b0, 1'b0, 32'h0);
      repeat (5) applyIdle();
      applyStimulus(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h55);
      applyStimulus(1'b0, 1'b1, 2'b11, 32'd50, 32'd5, 1'b0, 1'b0, 32'h0);
      @(posedge clk);
      #2;
      check1("mtlo_run_dropped", lo_o, 32'h5A);
      repeat (WIDTH - 7) applyIdle();
      @(posedge clk);
      #2;
      check1("done_after_ignored_start", {31'b0, done_o}, 32'd1);
      checkLiteral("multu_3_4", 32'h0, 32'hC);

      applyStimulus(1'b0, 1'b1, 2'b01, 32'd9, 32'd9, 1'b0, 1'b0, 32'h0);
      repeat (9) applyIdle();
      applyStimulus(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      @(posedge clk);
      #2;
      check1("rst_run_busy", {31'b0, busy_o}, 32'd0);
      check1("rst_run_done", {31'b0, done_o}, 32'd0);
      checkLiteral("rst_run", 32'h0, 32'h0);
      applyIdle();
      runOp(2'b01, 32'd6, 32'd7);
      checkLiteral("after_rst", 32'h0, 32'd42);

      for (int i = 0; i < 60; i++) begin
         applyStimulus(1'b0, 1'b1, 2'($urandom_range(0, 3)), pickOperand(), pickOperand(),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
         for (int c = 0; c < WIDTH; c++) begin
            applyStimulus(1'b0, ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), $urandom, $urandom,
                          ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), $urandom);
         end
         if ($urandom_range(0, 1) == 1) begin
            applyStimulus(1'b0, 1'b0, 2'b00, 32'h0, 32'h0,
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
         end
      end
      repeat (WIDTH + 2) applyIdle();
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
